// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: one-hot column drive, synchronized row sampling,
// press/release debounce and a small key-code FIFO with a valid/ready read port.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 25,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       overflow,
    input  logic       ovf_clr
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PUSH,
        ST_RELEASE
    } state_t;

    logic [3:0]       row_meta_q, row_s_q;
    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [3:0]       col_out_q, col_out_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [3:0]       fifo_mem [FIFO_DEPTH];

    logic row_sel;
    logic fifo_full;
    logic push_req;
    logic push;
    logic pop;
    logic ovf_set;

    assign row_sel   = row_s_q[row_idx_q];
    assign fifo_full = (count_q == CNT_FULL);
    assign key_valid = (count_q != '0);
    assign pop       = key_valid & key_ready;
    assign push_req  = (state_q == ST_PUSH);
    // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
    assign push      = push_req & (~fifo_full | pop);
    assign ovf_set   = push_req & fifo_full & ~pop;

    assign col_out  = col_out_q;
    assign overflow = overflow_q;
    assign key_code = key_valid ? fifo_mem[rd_ptr_q] : 4'b0000;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        deb_d     = deb_q;
        col_idx_d = col_idx_q;
        row_idx_d = row_idx_q;
        case (state_q)
            ST_SCAN: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (row_s_q != 4'b0000) begin
                        if (row_s_q[0])      row_idx_d = 2'd0;
                        else if (row_s_q[1]) row_idx_d = 2'd1;
                        else if (row_s_q[2]) row_idx_d = 2'd2;
                        else                 row_idx_d = 2'd3;
                        deb_d   = '0;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (row_sel) begin
                    if (deb_q == DEB_LAST) begin
                        deb_d   = '0;
                        state_d = ST_PUSH;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end else begin
                    deb_d   = '0;
                    div_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_PUSH: begin
                deb_d   = '0;
                state_d = ST_RELEASE;
            end
            default: begin
                if (!row_sel) begin
                    if (deb_q == DEB_LAST) begin
                        deb_d     = '0;
                        div_d     = '0;
                        col_idx_d = col_idx_q + 2'd1;
                        state_d   = ST_SCAN;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end else begin
                    deb_d = '0;
                end
            end
        endcase
        col_out_d = 4'b0001 << col_idx_d;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        overflow_d = ovf_set | (overflow_q & ~ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q <= 4'b0000;
            row_s_q    <= 4'b0000;
            state_q    <= ST_SCAN;
            div_q      <= '0;
            deb_q      <= '0;
            col_idx_q  <= 2'd0;
            row_idx_q  <= 2'd0;
            col_out_q  <= 4'b0001;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            row_meta_q <= row_in;
            row_s_q    <= row_meta_q;
            state_q    <= state_d;
            div_q      <= div_d;
            deb_q      <= deb_d;
            col_idx_q  <= col_idx_d;
            row_idx_q  <= row_idx_d;
            col_out_q  <= col_out_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; key_code is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {row_idx_q, col_idx_q};
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: a keypad model gates one pressed key by the
// driven column, and each step checks outputs against hand-computed values.
module tb_keypad_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       overflow;
    logic       ovf_clr;

    logic       press_en;
    logic [1:0] press_row;
    logic [1:0] press_col;

    int n_assert = 0;
    int n_fail   = 0;

    keypad_scan_ctrl #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (5),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    // A pressed key connects its row to its column, so it shows only while that column is driven.
    always_comb begin
        row_in = 4'b0000;
        if (press_en && col_out[press_col]) row_in = 4'b0001 << press_row;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick(1);
            if (key_valid === 1'b1) seen = 1'b1;
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    // Returns at the first negedge of a fresh dwell on the target column (divider at 0).
    task automatic align_col(input string tag, input logic [3:0] target);
        logic [3:0] prev;
        logic       found;
        prev  = col_out;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            tick(1);
            if (col_out === target && prev !== target) found = 1'b1;
            prev = col_out;
        end
        check(tag, {31'd0, found}, 32'd1);
    endtask

    task automatic press_key(input logic [1:0] r, input logic [1:0] c);
        press_row = r;
        press_col = c;
        press_en  = 1'b1;
        tick(40);
        press_en  = 1'b0;
        tick(15);
    endtask

    task automatic pop_check(input string tag, input logic [3:0] exp);
        check({tag, "_valid"}, {31'd0, key_valid}, 32'd1);
        check({tag, "_code"}, {28'd0, key_code}, {28'd0, exp});
        $display("pop %s: key_code=%b", tag, key_code);
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
    endtask

    initial begin
        logic [3:0] one_hot;
        int         rises;
        logic       flag;

        rst       = 1'b1;
        key_ready = 1'b0;
        ovf_clr   = 1'b0;
        press_en  = 1'b0;
        press_row = 2'd0;
        press_col = 2'd0;
        tick(3);
        rst = 1'b0;

        // Test 1: idle scan, four cycles per column, nothing queued.
        check("t1_reset_code", {28'd0, key_code}, 32'd0);
        check("t1_reset_ovf", {31'd0, overflow}, 32'd0);
        for (int k = 0; k <= 16; k++) begin
            one_hot = 4'b0001 << ((k / 4) % 4);
            check($sformatf("t1_col_k%0d", k), {28'd0, col_out}, {28'd0, one_hot});
            check($sformatf("t1_valid_k%0d", k), {31'd0, key_valid}, 32'd0);
            tick(1);
        end
        $display("t1 idle scan done");

        // Test 2: row 2 / col 1 held, consumer ready -> exactly one code 1001.
        key_ready = 1'b1;
        press_row = 2'd2;
        press_col = 2'd1;
        press_en  = 1'b1;
        wait_valid("t2_valid_timeout", 60);
        check("t2_code", {28'd0, key_code}, 32'h9);
        $display("t2 push: key_code=%b", key_code);
        tick(1);
        check("t2_popped", {31'd0, key_valid}, 32'd0);
        rises = 0;
        flag  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (key_valid !== 1'b0) rises++;
            if (col_out !== 4'b0010) flag = 1'b0;
        end
        check("t2_no_repeat", rises, 32'd0);
        check("t2_col_held", {31'd0, flag}, 32'd1);
        press_en = 1'b0;
        tick(9);
        check("t2_next_col", {28'd0, col_out}, 32'h4);

        // Test 3: a 3-cycle bounce on col 0 row 0 is rejected and scanning resumes on col 0.
        align_col("t3_align", 4'b0001);
        press_row = 2'd0;
        press_col = 2'd0;
        press_en  = 1'b1;
        tick(3);
        press_en  = 1'b0;
        flag = 1'b1;
        for (int i = 4; i <= 9; i++) begin
            tick(1);
            if (col_out !== 4'b0001 || key_valid !== 1'b0) flag = 1'b0;
        end
        check("t3_bounce_held_col0", {31'd0, flag}, 32'd1);
        tick(1);
        check("t3_col_after_bounce", {28'd0, col_out}, 32'h2);
        press_en = 1'b1;
        wait_valid("t3_valid_timeout", 60);
        check("t3_code", {28'd0, key_code}, 32'h0);
        $display("t3 push: key_code=%b", key_code);
        press_en = 1'b0;
        tick(15);

        // Test 4: five presses with no consumer -> four held, overflow set, then cleared.
        key_ready = 1'b0;
        press_key(2'd0, 2'd1);
        press_key(2'd1, 2'd2);
        press_key(2'd3, 2'd3);
        press_key(2'd2, 2'd0);
        press_key(2'd1, 2'd1);
        check("t4_valid", {31'd0, key_valid}, 32'd1);
        check("t4_head", {28'd0, key_code}, 32'h1);
        check("t4_ovf_set", {31'd0, overflow}, 32'd1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("t4_ovf_clr", {31'd0, overflow}, 32'd0);
        pop_check("t4_pop0", 4'b0001);
        pop_check("t4_pop1", 4'b0110);
        pop_check("t4_pop2", 4'b1111);
        pop_check("t4_pop3", 4'b1000);
        check("t4_empty", {31'd0, key_valid}, 32'd0);

        // Test 5: full FIFO, fifth press reaches PUSH in the same cycle as a pop.
        press_key(2'd0, 2'd0);
        press_key(2'd0, 2'd2);
        press_key(2'd1, 2'd3);
        press_key(2'd2, 2'd1);
        check("t5_full_head", {28'd0, key_code}, 32'h0);
        check("t5_full_no_ovf", {31'd0, overflow}, 32'd0);
        align_col("t5_align", 4'b0001);
        press_row = 2'd3;
        press_col = 2'd0;
        press_en  = 1'b1;
        tick(9);
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
        check("t5_ovf_stays0", {31'd0, overflow}, 32'd0);
        check("t5_head_after_pop", {28'd0, key_code}, 32'h2);
        press_en = 1'b0;
        tick(15);
        pop_check("t5_pop0", 4'b0010);
        pop_check("t5_pop1", 4'b0111);
        pop_check("t5_pop2", 4'b1001);
        pop_check("t5_pop3", 4'b1100);
        check("t5_empty", {31'd0, key_valid}, 32'd0);
        check("t5_ovf_final", {31'd0, overflow}, 32'd0);

        // Test 6a: reset while debouncing a key on col 2.
        align_col("t6_align", 4'b0100);
        press_row = 2'd1;
        press_col = 2'd2;
        press_en  = 1'b1;
        tick(5);
        rst      = 1'b1;
        press_en = 1'b0;
        tick(1);
        check("t6a_col", {28'd0, col_out}, 32'h1);
        check("t6a_valid", {31'd0, key_valid}, 32'd0);
        check("t6a_code", {28'd0, key_code}, 32'h0);
        check("t6a_ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        rises = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (key_valid !== 1'b0) rises++;
        end
        check("t6a_press_discarded", rises, 32'd0);

        // Test 6b: reset with two queued keys empties the FIFO.
        press_key(2'd3, 2'd2);
        press_key(2'd2, 2'd3);
        check("t6b_valid_before", {31'd0, key_valid}, 32'd1);
        check("t6b_head_before", {28'd0, key_code}, 32'hE);
        rst = 1'b1;
        tick(1);
        check("t6b_col", {28'd0, col_out}, 32'h1);
        check("t6b_valid", {31'd0, key_valid}, 32'd0);
        check("t6b_code", {28'd0, key_code}, 32'h0);
        check("t6b_ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        tick(2);
        check("t6b_still_empty", {31'd0, key_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
